// File: rtl/dbgslv_pkg.sv
// Shared types and default parameter values for the debug-slave command queue.
package dbgslv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PUSH = 2'd2
  } dbgslv_state_t;

  localparam int DEF_IR_W        = 2;
  localparam int DEF_DR_W        = 38;
  localparam int DEF_QDEPTH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SETTLE_CYC  = 1;

  // Settle counter width; covers SETTLE_CYC-1 up to 3.
  localparam int SETTLE_CW = 2;

endpackage

// File: rtl/dbgslv_sync_edge.sv
// Level synchroniser followed by a rising-edge detector (one-cycle pulse).
// The detector stays in the "previous = high" state until the synchroniser
// chain has been refilled after reset, so a level that is already high when
// reset is released never produces a pulse.
module dbgslv_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_vld;
  logic              r_prev;

  // Synchroniser chain, fill tracker and previous-value flop for the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_vld  <= '0;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_level};
      r_vld  <= {r_vld[STAGES-2:0], 1'b1};
      r_prev <= r_vld[STAGES-1] ? r_sync[STAGES-1] : 1'b1;
    end
  end

  assign o_pulse = r_vld[STAGES-1] & r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/dbgslv_sysclk_q.sv
// Debug-slave capture queue in the system clock domain.
// Synchronises the TCK-domain update-IR/update-DR levels, captures {ir, sr}
// after a settle delay and pushes it into a FWFT command queue. Popping an
// entry fires a one-hot action / no-action pulse selected by the entry's IR.
// Optional macro DBGSLV_DROP_CNT_EN builds the saturating drop counter;
// otherwise drop_cnt is tied to 0.
//
// state | meaning
// IDLE  | no capture in progress
// WAIT  | settle counter running after an update-DR edge
// PUSH  | write captured {ir_q, sr} to the queue tail
module dbgslv_sysclk_q
  import dbgslv_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int DR_W        = DEF_DR_W,
  parameter int QDEPTH      = DEF_QDEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int NCH         = 2**IR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vs_uir,
  input  logic                         vs_udr,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [DR_W-1:0]              sr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [DR_W-1:0]              cmd_data,
  output logic [NCH-1:0]               take_action,
  output logic [NCH-1:0]               take_no_action,
  output logic [$clog2(QDEPTH+1)-1:0]  q_level,
  output logic                         ovf_sticky,
  input  logic                         ovf_clr,
  output logic [7:0]                   drop_cnt
);

  localparam int LW = $clog2(QDEPTH+1);
  localparam int PW = $clog2(QDEPTH);
  localparam int EW = IR_W + DR_W;
  localparam logic [SETTLE_CW-1:0] SETTLE_LD = SETTLE_CW'(SETTLE_CYC-1);

  logic                 w_uir_pulse;
  logic                 w_udr_pulse;

  dbgslv_state_t        r_state;
  dbgslv_state_t        w_state_nx;
  logic [SETTLE_CW-1:0] r_cnt;
  logic [SETTLE_CW-1:0] w_cnt_nx;
  logic                 r_pend;
  logic                 w_pend_nx;
  logic                 w_cap_en;
  logic                 w_drop_pend;
  logic                 w_drop_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;

  logic [IR_W-1:0]      r_ir_q;
  logic [DR_W-1:0]      r_cap_sr;

  logic [EW-1:0]        r_mem [QDEPTH];
  logic [PW-1:0]        r_wr;
  logic [PW-1:0]        r_rd;
  logic [LW-1:0]        r_level;
  logic [EW-1:0]        w_head;
  logic [NCH-1:0]       w_onehot;

  logic [NCH-1:0]       r_take_action;
  logic [NCH-1:0]       r_take_no_action;
  logic                 r_ovf_sticky;

  dbgslv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset   (reset),
    .i_level (vs_uir),
    .o_pulse (w_uir_pulse)
  );

  dbgslv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset   (reset),
    .i_level (vs_udr),
    .o_pulse (w_udr_pulse)
  );

  // ir_in is quasi-static by the time update-IR has crossed the synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir_q <= '0;
    end else if (w_uir_pulse) begin
      r_ir_q <= ir_in;
    end
  end

  // Capture FSM state, settle counter, pending flag and captured shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_cap_sr <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      if (w_cap_en) r_cap_sr <= sr;
    end
  end

  // Next-state logic. A pending event left over when PUSH returns to IDLE is
  // picked up from IDLE so it is never stranded.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_pend_nx   = r_pend;
    w_cap_en    = 1'b0;
    w_drop_pend = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = SETTLE_LD;
          w_pend_nx  = w_udr_pulse;
        end else if (w_udr_pulse) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = SETTLE_LD;
        end
      end
      ST_WAIT: begin
        if (w_udr_pulse) begin
          if (r_pend) w_drop_pend = 1'b1;
          else        w_pend_nx   = 1'b1;
        end
        if (r_cnt == '0) begin
          w_state_nx = ST_PUSH;
          w_cap_en   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_PUSH: begin
        if (r_pend) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = SETTLE_LD;
          w_pend_nx  = 1'b0;
        end else begin
          w_state_nx = ST_IDLE;
        end
        if (w_udr_pulse) begin
          if (r_pend) w_drop_pend = 1'b1;
          else        w_pend_nx   = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: queue write, or a drop when full with no same-cycle pop.
  always_comb begin
    w_push      = 1'b0;
    w_drop_full = 1'b0;
    if (r_state == ST_PUSH) begin
      if (!w_full || w_pop) w_push      = 1'b1;
      else                  w_drop_full = 1'b1;
    end
  end

  assign w_full = (r_level == LW'(QDEPTH));
  assign w_pop  = cmd_valid && cmd_ready;

  // Queue storage; pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_ir_q, r_cap_sr};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd];
  assign cmd_valid = (r_level != '0);
  assign cmd_ir    = w_head[EW-1:DR_W];
  assign cmd_data  = w_head[DR_W-1:0];
  assign q_level   = r_level;
  assign w_onehot  = {{(NCH-1){1'b0}}, 1'b1} << cmd_ir;

  // One-cycle action pulses for the entry popped this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        if (cmd_data[DR_W-1]) r_take_action    <= w_onehot;
        else                  r_take_no_action <= w_onehot;
      end
    end
  end

  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;

  // Overflow flag; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_drop_full || w_drop_pend) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;

`ifdef DBGSLV_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  // A full-queue drop and a pending overflow can land in the same cycle.
  assign w_drop_sum = {1'b0, (ovf_clr ? 8'd0 : r_drop_cnt)}
                    + {8'd0, w_drop_full} + {8'd0, w_drop_pend};

  // Saturating drop counter, cleared together with the overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dbgslv_sysclk_q.sv
// Directed bench for dbgslv_sysclk_q: one default instance and one with a
// long settle time (SETTLE_CYC=4) so pending-flag overflow is reachable.
module tb_dbgslv_sysclk_q;

  localparam int IR_W   = 2;
  localparam int DR_W   = 38;
  localparam int NCH    = 4;
  localparam int LW     = 3;
`ifdef DBGSLV_DROP_CNT_EN
  localparam logic [7:0] DROP1 = 8'd1;
`else
  localparam logic [7:0] DROP1 = 8'd0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            vs_uir = 1'b0;
  logic            vs_udr = 1'b0;
  logic            cmd_ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [DR_W-1:0] sr = '0;

  logic            cmd_valid, s_cmd_valid;
  logic [IR_W-1:0] cmd_ir, s_cmd_ir;
  logic [DR_W-1:0] cmd_data, s_cmd_data;
  logic [NCH-1:0]  take_action, s_take_action;
  logic [NCH-1:0]  take_no_action, s_take_no_action;
  logic [LW-1:0]   q_level, s_q_level;
  logic            ovf_sticky, s_ovf_sticky;
  logic [7:0]      drop_cnt, s_drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbgslv_sysclk_q u_dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .take_action(take_action),
    .take_no_action(take_no_action), .q_level(q_level),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  dbgslv_sysclk_q #(.SETTLE_CYC(4)) u_dut_s (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_valid(s_cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .take_action(s_take_action),
    .take_no_action(s_take_no_action), .q_level(s_q_level),
    .ovf_sticky(s_ovf_sticky), .ovf_clr(ovf_clr), .drop_cnt(s_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic do_uir(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    tick(3);
  endtask

  task automatic pulse_udr(input logic [DR_W-1:0] v);
    sr     = v;
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, slat, acyc, nact;
    logic [NCH-1:0]  aval;
    logic [IR_W-1:0] vir;
    logic [DR_W-1:0] vdat;
    logic [DR_W-1:0] drain_exp [4];

    #2;
    reset = 1'b1;
    #2;
    check("rst_q_level", 64'(q_level), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_ovf", 64'(ovf_sticky), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_actions", 64'({take_action, take_no_action}), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(3);

    // Basic action path and end-to-end latency.
    do_uir(2'd2);
    sr = 38'h20_0000_0055;
    cmd_ready = 1'b1;
    lat = -1; slat = -1; acyc = -1; aval = '0; vir = '0; vdat = '0; nact = 0;
    vs_udr = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 3) vs_udr = 1'b0;
      if (cmd_valid && lat < 0) begin
        lat = k; vir = cmd_ir; vdat = cmd_data;
      end
      if (s_cmd_valid && slat < 0) slat = k;
      if (take_action != '0 && acyc < 0) begin
        acyc = k; aval = take_action;
      end
      if (take_no_action != '0) nact++;
    end
    check("latency_default", 64'(lat), 64'd5);
    check("latency_settle4", 64'(slat), 64'd8);
    check("head_ir", 64'(vir), 64'd2);
    check("head_data", 64'(vdat), 64'h20_0000_0055);
    check("action_cycle", 64'(acyc), 64'd6);
    check("action_value", 64'(aval), 64'b0100);
    check("no_action_quiet", 64'(nact), 64'd0);
    check("action_cleared", 64'(take_action), 64'd0);
    check("q_empty_after_pop", 64'(q_level), 64'd0);

    // No-action path: MSB clear, ir=3.
    do_uir(2'd3);
    sr = 38'h00_0000_00AA;
    aval = '0; nact = 0;
    vs_udr = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 3) vs_udr = 1'b0;
      if (take_no_action != '0) aval = take_no_action;
      if (take_action != '0) nact++;
    end
    check("no_action_value", 64'(aval), 64'b1000);
    check("action_stays_0", 64'(nact), 64'd0);

    // Fill the queue, then overflow it.
    cmd_ready = 1'b0;
    do_uir(2'd1);
    for (int i = 1; i <= 4; i++) pulse_udr(DR_W'(i));
    check("full_level", 64'(q_level), 64'd4);
    check("full_head", 64'(cmd_data), 64'd1);
    check("full_no_ovf", 64'(ovf_sticky), 64'd0);
    pulse_udr(38'h99);
    check("ovf_level", 64'(q_level), 64'd4);
    check("ovf_sticky", 64'(ovf_sticky), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'(DROP1));
    check("ovf_head", 64'(cmd_data), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("clr_sticky", 64'(ovf_sticky), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);

    // Full queue with a pop in the PUSH cycle: push accepted, no drop.
    sr = 38'h66;
    vs_udr = 1'b1;
    tick(4);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("pushpop_level", 64'(q_level), 64'd4);
    check("pushpop_no_ovf", 64'(ovf_sticky), 64'd0);
    check("pushpop_head", 64'(cmd_data), 64'd2);
    check("pushpop_no_action", 64'(take_no_action), 64'b0010);
    check("pushpop_action_0", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    tick(4);
    check("pushpop_drop_cnt", 64'(drop_cnt), 64'd0);

    // Drain across the pointer wrap.
    drain_exp[0] = 38'd2;
    drain_exp[1] = 38'd3;
    drain_exp[2] = 38'd4;
    drain_exp[3] = 38'h66;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), 64'(cmd_data), 64'(drain_exp[i]));
      cmd_ready = 1'b1;
      tick(1);
    end
    check("drained_level", 64'(q_level), 64'd0);
    check("drained_valid", 64'(cmd_valid), 64'd0);
    tick(3);
    check("ready_empty_level", 64'(q_level), 64'd0);
    check("ready_empty_actions", 64'({take_action, take_no_action}), 64'd0);
    cmd_ready = 1'b0;

    // update-IR arriving during WAIT is used by the push.
    do_reset();
    do_uir(2'd1);
    sr = 38'h77;
    vs_udr = 1'b1;
    tick(1);
    ir_in = 2'd3;
    vs_uir = 1'b1;
    tick(3);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(10);
    check("uir_in_wait_ir", 64'(cmd_ir), 64'd3);
    check("uir_in_wait_ir_s", 64'(s_cmd_ir), 64'd3);
    check("uir_in_wait_level_s", 64'(s_q_level), 64'd1);

    // Three update-DR edges two cycles apart into the long-settle instance.
    do_reset();
    sr = 38'h11;
    for (int i = 0; i < 3; i++) begin
      vs_udr = 1'b1;
      tick(1);
      vs_udr = 1'b0;
      tick(1);
    end
    tick(20);
    check("pend_level_s", 64'(s_q_level), 64'd2);
    check("pend_ovf_s", 64'(s_ovf_sticky), 64'd1);
    check("pend_drop_cnt_s", 64'(s_drop_cnt), 64'(DROP1));

    // Reset during WAIT, with update-DR held high across deassertion.
    do_reset();
    vs_udr = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check("rst_wait_level_s", 64'(s_q_level), 64'd0);
    check("rst_wait_valid", 64'({cmd_valid, s_cmd_valid}), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(15);
    check("held_high_level", 64'({q_level, s_q_level}), 64'd0);
    check("held_high_valid", 64'({cmd_valid, s_cmd_valid}), 64'd0);
    vs_udr = 1'b0;
    tick(5);
    check("held_high_after_low", 64'(q_level), 64'd0);
    pulse_udr(38'h5);
    tick(2);
    check("post_reset_event", 64'(q_level), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dbgslv_sysclk_q.md
DBGSLV_SYSCLK_Q -- requirements
Module: dbgslv_sysclk_q

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- IR_W, 2, instruction width.
- DR_W, 38, data-register width.
- QDEPTH, 4, command queue depth (power of 2, 2..16).
- SYNC_STAGES, 2, synchroniser depth (2..3).
- SETTLE_CYC, 1, post-edge settle cycles (1..4).
- NCH = 2**IR_W, derived.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock; the only clock.
- reset, in, 1, asynchronous, active-high reset.
- vs_uir, in, 1, update-IR level from the TCK domain (asynchronous).
- vs_udr, in, 1, update-DR level from the TCK domain (asynchronous).
- ir_in, in, IR_W, instruction register (quasi-static).
- sr, in, DR_W, shift register contents (quasi-static).
- cmd_valid, out, 1, queue head valid.
- cmd_ready, in, 1, consumer accepts head.
- cmd_ir, out, IR_W, head instruction.
- cmd_data, out, DR_W, head data (jdo).
- take_action, out, NCH, one-hot action pulse.
- take_no_action, out, NCH, one-hot no-action pulse.
- q_level, out, $clog2(QDEPTH+1), queue occupancy.
- ovf_sticky, out, 1, event dropped since the last clear.
- ovf_clr, in, 1, clears ovf_sticky.
- drop_cnt, out, 8, saturating drop count.

Function
REQ-003 vs_uir and vs_udr SHALL each pass through SYNC_STAGES flops and then a rising-edge detector, producing a 1-cycle pulse each.
REQ-004 On the uir pulse, ir_q SHALL load the synchronised sampling of ir_in.
REQ-005 The capture FSM SHALL use states IDLE, WAIT, and PUSH:
- IDLE -> WAIT on the udr pulse, loading the settle counter with SETTLE_CYC-1.
- WAIT decrements the counter and goes to PUSH at 0, sampling sr into the capture register on that transition.
- PUSH -> IDLE, or -> WAIT if the pending flag is set (clearing the flag).
REQ-006 In PUSH, {ir_q, captured sr} SHALL be written to the queue tail unless the queue is full and no pop occurs in the same cycle.
REQ-007 A udr pulse arriving in WAIT or PUSH SHALL set a one-deep pending flag; a udr pulse while pending is already set SHALL be dropped.
REQ-008 Each dropped event (queue full per REQ-006, or pending overflow per REQ-007) SHALL set ovf_sticky.
REQ-009 On a simultaneous drop and ovf_clr, the set SHALL win.
REQ-010 The queue SHALL be a FWFT FIFO: cmd_valid = (q_level != 0), and cmd_ir/cmd_data show the head.
REQ-011 A pop SHALL occur when cmd_valid && cmd_ready; cmd_ready while empty SHALL have no effect.
REQ-012 Simultaneous push and pop SHALL keep q_level unchanged, including at full and at empty+1.
REQ-013 Read and write pointers SHALL wrap modulo QDEPTH.
REQ-014 take_action[cmd_ir] SHALL pulse for 1 cycle, registered, in the cycle after a pop when cmd_data[DR_W-1]=1; take_no_action[cmd_ir] SHALL pulse instead when that bit is 0. All other bits SHALL be 0.
REQ-015 Latency SHALL be exactly SYNC_STAGES+SETTLE_CYC+2 cycles from the first clk edge sampling vs_udr high to cmd_valid high, with the queue empty (defaults: 5).
REQ-016 A uir pulse coinciding with WAIT SHALL update ir_q, and the push SHALL use the new value.

Reset
REQ-017 Reset SHALL clear all sync flops, FSM (-> IDLE), pending flag, pointers, q_level, ovf_sticky, drop_cnt, take_action, take_no_action, and ir_q to 0, and cmd_valid to 0.
REQ-018 An event in flight at reset SHALL be discarded.
REQ-019 No spurious pulse SHALL follow deassertion while vs_udr is held high: the edge detectors SHALL reset to the "previous = high-safe" value of 1.

Configuration
REQ-020 With DBGSLV_DROP_CNT_EN defined, drop_cnt SHALL increment on every dropped event, saturate at 255, and clear on ovf_clr.
REQ-021 Without DBGSLV_DROP_CNT_EN, drop_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-022 Package dbgslv_pkg SHALL hold the FSM state enum (IDLE/WAIT/PUSH) and the default parameter constants.
REQ-023 Sub-module dbgslv_sync_edge SHALL implement the synchroniser plus edge detector and be instantiated twice.

Verification
REQ-024 Defaults: uir with ir_in=2, then udr with sr=38'h20_0000_0055 and cmd_ready=1 -> cmd_valid at cycle 5, cmd_ir=2, take_action=4'b0100 one cycle after the pop.
REQ-025 Push 4 events with cmd_ready=0 -> q_level=4; a 5th event -> dropped, ovf_sticky=1, drop_cnt=1; the queue head is unchanged.
REQ-026 Full queue, cmd_ready=1 during a PUSH -> push accepted, q_level stays 4, no drop.
REQ-027 Three udr edges 2 cycles apart -> first two queued (one via pending), third dropped, drop_cnt=1.
REQ-028 Reset asserted in WAIT -> q_level=0, no cmd_valid; vs_udr held high across reset deassertion -> no event.
REQ-029 sr MSB=0, ir=3 -> take_no_action=4'b1000; take_action stays 0.
